// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
// Commit-trace capture FIFO that sits beside the WB stage of the 5-stage MIPS
// pipeline. Every register-file writeback is stored as a record
// {cycle stamp, destination register, write data}. A downstream consumer
// drains the records over a valid/ready handshake.
//
// The FIFO is first-word fall-through. The head record is held in a register
// that is refreshed from the next-state pointers, so the trace_* outputs never
// see a combinational path from wb_* or trace_ready.
//
// Compile option:
//   TRACE_FILTER_R0_EN - when defined, commits to $zero (wb_dest == 0) are
//                        discarded silently. They are neither stored nor
//                        counted as drops.
module wb_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       wb_reg_write,
    input  logic [4:0]                 wb_dest,
    input  logic [31:0]                wb_data,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [CNT_W-1:0]           trace_cycle,
    output logic [4:0]                 trace_dest,
    output logic [31:0]                trace_data,
    output logic [$clog2(DEPTH):0]     trace_level,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = CNT_W + 5 + 32;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Record storage; no reset needed because occupancy lives in level_reg.
    logic [REC_W-1:0] rec_mem [DEPTH];

    logic [CNT_W-1:0] cycle_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    logic             overflow_reg;
    logic [7:0]       drop_reg;
    logic [REC_W-1:0] head_reg;
    logic [REC_W-1:0] head_next;

    logic             push_req;
    logic             push;
    logic             pop;
    logic             full;
    logic             drop;
    logic [REC_W-1:0] new_rec;

    // A commit is a candidate for capture unless it targets $zero and filtering is on.
`ifdef TRACE_FILTER_R0_EN
    assign push_req = wb_reg_write && (wb_dest != 5'd0);
`else
    assign push_req = wb_reg_write;
`endif

    assign full    = (level_reg == LVL_FULL);
    assign pop     = (level_reg != '0) && trace_ready;
    // When the FIFO is full, a simultaneous pop frees the slot that this push uses.
    assign push    = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;
    assign new_rec = {cycle_reg, wb_dest, wb_data};

    // Next occupancy, next read pointer and next head record.
    always_comb begin
        level_next  = level_reg;
        rd_ptr_next = rd_ptr_reg;
        head_next   = '0;

        if (push && !pop) begin
            level_next = level_reg + LVL_ONE;
        end else if (pop && !push) begin
            level_next = level_reg - LVL_ONE;
        end

        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end

        // The incoming record becomes the head when nothing older remains
        // after this edge's pop. Otherwise the head comes from storage.
        if (level_next == '0) begin
            head_next = '0;
        end else if (push && ((level_reg == '0) || ((level_reg == LVL_ONE) && pop))) begin
            head_next = new_rec;
        end else begin
            head_next = rec_mem[rd_ptr_next];
        end
    end

    // Record storage write at the tail.
    always_ff @(posedge CLK) begin
        if (push) begin
            rec_mem[wr_ptr_reg] <= new_rec;
        end
    end

    // Free-running cycle counter that provides the commit timestamps.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + CNT_W'(1);
        end
    end

    // Pointers, occupancy and the registered head record.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            head_reg   <= head_next;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_reg <= 1'b0;
            drop_reg     <= '0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_reg != 8'hFF) begin
                drop_reg <= drop_reg + 8'd1;
            end
        end
    end

    assign trace_valid = (level_reg != '0);
    assign trace_cycle = head_reg[REC_W-1 -: CNT_W];
    assign trace_dest  = head_reg[36:32];
    assign trace_data  = head_reg[31:0];
    assign trace_level = level_reg;
    assign overflow    = overflow_reg;
    assign drop_count  = drop_reg;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Testbench for wb_trace_buffer. A DEPTH=8/CNT_W=16 instance is the main
// target. A CNT_W=4 instance shares the same stimulus and is used to check
// cycle-stamp wraparound.
module tb_wb_trace_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int SCNT_W = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              CLK;
    logic              RST;
    logic              wb_reg_write;
    logic [4:0]        wb_dest;
    logic [31:0]       wb_data;
    logic              trace_ready;

    logic              trace_valid;
    logic [CNT_W-1:0]  trace_cycle;
    logic [4:0]        trace_dest;
    logic [31:0]       trace_data;
    logic [LVL_W-1:0]  trace_level;
    logic              overflow;
    logic [7:0]        drop_count;

    logic              s_valid;
    logic [SCNT_W-1:0] s_cycle;
    logic [4:0]        s_dest;
    logic [31:0]       s_data;
    logic [LVL_W-1:0]  s_level;
    logic              s_overflow;
    logic [7:0]        s_drop;

    wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .wb_reg_write (wb_reg_write),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_cycle  (trace_cycle),
        .trace_dest   (trace_dest),
        .trace_data   (trace_data),
        .trace_level  (trace_level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(SCNT_W)) dut_small (
        .CLK          (CLK),
        .RST          (RST),
        .wb_reg_write (wb_reg_write),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .trace_valid  (s_valid),
        .trace_ready  (trace_ready),
        .trace_cycle  (s_cycle),
        .trace_dest   (s_dest),
        .trace_data   (s_data),
        .trace_level  (s_level),
        .overflow     (s_overflow),
        .drop_count   (s_drop)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        ready;
        logic        exp_valid;
        logic [4:0]  exp_dest;
        logic [31:0] exp_data;
        logic [3:0]  exp_level;
        logic        exp_ovf;
        logic [7:0]  exp_drop;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag, input int v, input int d, input int dat,
                               input int lvl, input int ovf, input int drp);
        check({tag, ".valid"}, 64'(trace_valid), 64'(v));
        check({tag, ".dest"},  64'(trace_dest),  64'(d));
        check({tag, ".data"},  64'(trace_data),  64'(dat));
        check({tag, ".level"}, 64'(trace_level), 64'(lvl));
        check({tag, ".ovf"},   64'(overflow),    64'(ovf));
        check({tag, ".drop"},  64'(drop_count),  64'(drp));
    endtask

    task automatic add_vec(input logic wr, input int dest, input int data, input logic ready,
                           input logic ev, input int ed, input int edat, input int el,
                           input logic eovf, input int edrop);
        vec_t v;
        v.wr        = wr;
        v.dest      = 5'(dest);
        v.data      = 32'(data);
        v.ready     = ready;
        v.exp_valid = ev;
        v.exp_dest  = 5'(ed);
        v.exp_data  = 32'(edat);
        v.exp_level = 4'(el);
        v.exp_ovf   = eovf;
        v.exp_drop  = 8'(edrop);
        vecs.push_back(v);
    endtask

    initial begin
        // ---------------- vector table ----------------
        // Ten commits with no consumer: eight are kept, two are dropped.
        for (int i = 1; i <= 10; i++)
            add_vec(1'b1, i, i, 1'b0, 1'b1, 1, 1, (i < 8) ? i : 8, (i > 8), (i > 8) ? i - 8 : 0);
        // Drain: records 1..8 come out in order.
        for (int k = 1; k <= 8; k++)
            add_vec(1'b0, 0, 0, 1'b1, (k < 8), (k < 8) ? k + 1 : 0, (k < 8) ? k + 1 : 0,
                    8 - k, 1'b1, 2);
        // Refill with 1..8.
        for (int i = 1; i <= 8; i++)
            add_vec(1'b1, i, i, 1'b0, 1'b1, 1, 1, i, 1'b1, 2);
        // Full, then push 99 and pop simultaneously.
        add_vec(1'b1, 3, 99, 1'b1, 1'b1, 2, 2, 8, 1'b1, 2);
        // Drain 2..8, then 99 last.
        for (int k = 1; k <= 8; k++) begin
            if (k < 7)       add_vec(1'b0, 0, 0, 1'b1, 1'b1, k + 2, k + 2, 8 - k, 1'b1, 2);
            else if (k == 7) add_vec(1'b0, 0, 0, 1'b1, 1'b1, 3, 99, 1, 1'b1, 2);
            else             add_vec(1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 2);
        end
        // Backpressure: queue three records, then ready = 1,0,0,1,1.
        add_vec(1'b1, 9,  'hA1, 1'b0, 1'b1, 9, 'hA1, 1, 1'b1, 2);
        add_vec(1'b1, 10, 'hA2, 1'b0, 1'b1, 9, 'hA1, 2, 1'b1, 2);
        add_vec(1'b1, 11, 'hA3, 1'b0, 1'b1, 9, 'hA1, 3, 1'b1, 2);
        add_vec(1'b0, 0, 0, 1'b1, 1'b1, 10, 'hA2, 2, 1'b1, 2);
        add_vec(1'b0, 0, 0, 1'b0, 1'b1, 10, 'hA2, 2, 1'b1, 2);
        add_vec(1'b0, 0, 0, 1'b0, 1'b1, 10, 'hA2, 2, 1'b1, 2);
        add_vec(1'b0, 0, 0, 1'b1, 1'b1, 11, 'hA3, 1, 1'b1, 2);
        add_vec(1'b0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 2);

        // ---------------- reset, then single commit ----------------
        RST = 1'b1; wb_reg_write = 1'b0; wb_dest = '0; wb_data = '0; trace_ready = 1'b0;
        tick();
        tick();
        check_state("reset", 0, 0, 0, 0, 0, 0);
        check("reset.cycle", 64'(trace_cycle), 64'd0);
        RST = 1'b0;
        // The counter reads 0, 1, 2 in the first three idle cycles; the commit is stamped 3.
        tick(); tick(); tick();
        wb_reg_write = 1'b1; wb_dest = 5'd8; wb_data = 32'd42;
        #1;
        check_state("precommit", 0, 0, 0, 0, 0, 0);
        tick();
        $display("txn commit dest=8 data=42 -> valid=%b cycle=%0d level=%0d",
                 trace_valid, trace_cycle, trace_level);
        check_state("commit", 1, 8, 42, 1, 0, 0);
        check("commit.cycle", 64'(trace_cycle), 64'd3);
        wb_reg_write = 1'b0; trace_ready = 1'b1;
        tick();
        $display("txn pop -> valid=%b level=%0d", trace_valid, trace_level);
        check_state("pop1", 0, 0, 0, 0, 0, 0);
        check("pop1.cycle", 64'(trace_cycle), 64'd0);
        trace_ready = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            wb_reg_write = vecs[i].wr;
            wb_dest      = vecs[i].dest;
            wb_data      = vecs[i].data;
            trace_ready  = vecs[i].ready;
            tick();
            $display("vec %0d: wr=%b dest=%0d data=%0h rdy=%b -> valid=%b dest=%0d data=%0h lvl=%0d ovf=%b drop=%0d",
                     i, vecs[i].wr, vecs[i].dest, vecs[i].data, vecs[i].ready,
                     trace_valid, trace_dest, trace_data, trace_level, overflow, drop_count);
            check_state($sformatf("vec%0d", i), int'(vecs[i].exp_valid), int'(vecs[i].exp_dest),
                        int'(vecs[i].exp_data), int'(vecs[i].exp_level), int'(vecs[i].exp_ovf),
                        int'(vecs[i].exp_drop));
        end
        wb_reg_write = 1'b0; trace_ready = 1'b0;

        // ---------------- counter wrap (CNT_W=4 instance) ----------------
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("wrap.reset_level", 64'(s_level), 64'd0);
        check("wrap.reset_ovf", 64'(s_overflow), 64'd0);
        for (int i = 0; i < 15; i++) tick();
        wb_reg_write = 1'b1; wb_dest = 5'd1; wb_data = 32'h15;
        tick();
        wb_reg_write = 1'b0;
        $display("txn wrap commit A -> small cycle=%0d big cycle=%0d", s_cycle, trace_cycle);
        check("wrap.stampA_small", 64'(s_cycle), 64'd15);
        check("wrap.stampA_big", 64'(trace_cycle), 64'd15);
        tick();
        wb_reg_write = 1'b1; wb_dest = 5'd2; wb_data = 32'h17;
        tick();
        wb_reg_write = 1'b0;
        check("wrap.level", 64'(s_level), 64'd2);
        check("wrap.head_hold", 64'(s_cycle), 64'd15);
        trace_ready = 1'b1;
        tick();
        $display("txn wrap pop -> small cycle=%0d big cycle=%0d", s_cycle, trace_cycle);
        check("wrap.stampB_small", 64'(s_cycle), 64'd1);
        check("wrap.stampB_big", 64'(trace_cycle), 64'd17);
        check("wrap.destB", 64'(s_dest), 64'd2);
        tick();
        check("wrap.empty", 64'(s_valid), 64'd0);
        trace_ready = 1'b0;

        // ---------------- reset mid-drain ----------------
        for (int i = 1; i <= 9; i++) begin
            wb_reg_write = 1'b1; wb_dest = 5'(i); wb_data = 32'(100 + i);
            tick();
        end
        wb_reg_write = 1'b0;
        check_state("prefill", 1, 1, 101, 8, 1, 1);
        trace_ready = 1'b1;
        tick(); tick(); tick();
        check_state("middrain", 1, 4, 104, 5, 1, 1);
        RST = 1'b1;
        tick();
        $display("txn reset mid-drain -> valid=%b level=%0d drop=%0d", trace_valid, trace_level, drop_count);
        check_state("rstdrain", 0, 0, 0, 0, 0, 0);
        check("rstdrain.cycle", 64'(trace_cycle), 64'd0);
        RST = 1'b0;

        // ---------------- $zero commit (pop into empty is also ignored) ----------------
        wb_reg_write = 1'b1; wb_dest = 5'd0; wb_data = 32'd7; trace_ready = 1'b1;
        tick();
        wb_reg_write = 1'b0; trace_ready = 1'b0;
        $display("txn commit dest=0 -> level=%0d", trace_level);
`ifdef TRACE_FILTER_R0_EN
        check_state("r0", 0, 0, 0, 0, 0, 0);
`else
        check_state("r0", 1, 0, 7, 1, 0, 0);
`endif
        wb_reg_write = 1'b1; wb_dest = 5'd4; wb_data = 32'd8;
        tick();
        wb_reg_write = 1'b0;
        $display("txn commit dest=4 -> level=%0d head=%0d", trace_level, trace_data);
`ifdef TRACE_FILTER_R0_EN
        check_state("r0next", 1, 4, 8, 1, 0, 0);
`else
        check_state("r0next", 1, 0, 7, 2, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
